s3g_packet_tx: RTL and testbench



---
 rtl/s3g_packet_tx.sv | 179 +++++++++++++++++
 tb/tb_s3g_packet_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s3g_packet_tx.sv
// S3G packet framer: emits HEADER, length, payload bytes, CRC-8 (Dallas/Maxim) to a byte UART.
// Latency: first byte one cycle after start; each later byte one cycle after tx_done.
// Backpressure: paced entirely by tx_done; start/resend/buffer writes ignored while busy. Option: S3G_TX_RESEND_EN.
module s3g_packet_tx #(
    parameter int          MAX_PAYLOAD = 32,
    parameter int          ADDR_W      = 5,
    parameter logic [7:0]  HEADER      = 8'hD5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buf_wr,
    input  logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_data,
    input  logic              packet_wr,
    input  logic [7:0]        payload_len,
    input  logic              resend,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_done,
    output logic              busy,
    output logic              len_err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4
    } state_t;

    localparam logic [7:0]      MAX_LEN = 8'(MAX_PAYLOAD);
    localparam logic [ADDR_W:0] DEPTH   = (ADDR_W+1)'(MAX_PAYLOAD);

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] crc_q, crc_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_wr_q, tx_wr_d;
    logic       busy_q, busy_d;
    logic       len_err_q, len_err_d;
    logic       start;
    logic [7:0] start_len;
    logic [7:0] rd_byte;

    // Payload store has no reset: contents must survive packets and reset.
    logic [7:0] mem_q [MAX_PAYLOAD];

    always_ff @(posedge clk) begin
        if (buf_wr && !busy_q && ({1'b0, buf_addr} < DEPTH)) begin
            mem_q[buf_addr] <= buf_data;
        end
    end

    // Asynchronous read keeps the next byte available in the same cycle as tx_done.
    assign rd_byte = mem_q[cnt_q[ADDR_W-1:0]];

`ifdef S3G_TX_RESEND_EN
    logic last_vld_q, last_vld_d;

    always_comb begin
        start     = (packet_wr && (payload_len <= MAX_LEN)) || (!packet_wr && resend && last_vld_q);
        start_len = packet_wr ? payload_len : len_q;
        last_vld_d = last_vld_q | ((state_q == ST_IDLE) && start);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld_q <= 1'b0;
        end else begin
            last_vld_q <= last_vld_d;
        end
    end
`else
    logic resend_unused;
    assign resend_unused = resend;

    always_comb begin
        start     = packet_wr && (payload_len <= MAX_LEN);
        start_len = payload_len;
    end
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        busy_d    = busy_q;
        len_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = start_len;
                    crc_d     = 8'h00;
                    tx_data_d = HEADER;
                    tx_wr_d   = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_HDR;
                end else if (packet_wr) begin
                    len_err_d = 1'b1;
                end
            end
            ST_HDR: begin
                if (tx_done) begin
                    tx_data_d = len_q;
                    tx_wr_d   = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = ST_LEN;
                end
            end
            // Once cnt reaches len every payload byte is out, so the CRC follows.
            ST_LEN, ST_DATA: begin
                if (tx_done) begin
                    tx_wr_d = 1'b1;
                    if (cnt_q == len_q) begin
                        tx_data_d = crc_q;
                        state_d   = ST_CRC;
                    end else begin
                        tx_data_d = rd_byte;
                        crc_d     = crc8_step(crc_q, rd_byte);
                        cnt_d     = cnt_q + 8'd1;
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_CRC: begin
                if (tx_done) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= 8'h00;
            cnt_q     <= 8'h00;
            crc_q     <= 8'h00;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
            busy_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            busy_q    <= busy_d;
            len_err_q <= len_err_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_wr   = tx_wr_q;
    assign busy    = busy_q;
    assign len_err = len_err_q;

endmodule

// File: tb/tb_s3g_packet_tx.sv
// Bench for s3g_packet_tx: random buffer contents and lengths, UART responder, byte scoreboard.
// Expected bytes come from a reference buffer copy and a bit-serial CRC-8 model.
module tb_s3g_packet_tx;
    localparam int         MAXP = 20;
    localparam int         AW   = 5;
    localparam logic [7:0] HDR  = 8'hD5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          buf_wr = 1'b0;
    logic [AW-1:0] buf_addr = '0;
    logic [7:0]    buf_data = 8'h00;
    logic          packet_wr = 1'b0;
    logic [7:0]    payload_len = 8'h00;
    logic          resend = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_wr;
    logic          tx_done = 1'b0;
    logic          busy;
    logic          len_err;

    s3g_packet_tx #(.MAX_PAYLOAD(MAXP), .ADDR_W(AW), .HEADER(HDR)) dut (
        .clk(clk), .rst(rst), .buf_wr(buf_wr), .buf_addr(buf_addr), .buf_data(buf_data),
        .packet_wr(packet_wr), .payload_len(payload_len), .resend(resend),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done), .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         tx_cnt = 0;
    int         uart_dly = 0;
    int         ucnt = 0;
    logic       prev_wr = 1'b0;
    logic [7:0] exp_b;
    logic [7:0] exp_q[$];
    logic [7:0] ref_mem[MAXP];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] ref_crc(input int len);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ ref_mem[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 8'h8C;
            end
        end
        return c;
    endfunction

    task automatic push_pkt(input int len);
        exp_q.push_back(HDR);
        exp_q.push_back(len[7:0]);
        for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[i]);
        exp_q.push_back(ref_crc(len));
    endtask

    // UART model: tx_done some cycles after each accepted byte.
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (rst) begin
            ucnt = 0;
        end else begin
            if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) tx_done = 1'b1;
            end
            if (tx_wr) ucnt = (uart_dly > 0) ? uart_dly : int'($urandom_range(1, 4));
        end
    end

    // Monitor: every tx_wr pops one expected byte.
    always @(negedge clk) begin
        if (tx_wr) begin
            tx_cnt++;
            check("tx_wr_gap", {31'b0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tx_wr actual=0x%0h required=none", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                check("tx_byte", {24'b0, tx_data}, {24'b0, exp_b});
            end
        end
        prev_wr = tx_wr;
    end

    task automatic wr(input int a, input logic [7:0] d, input bit accept);
        @(negedge clk);
        buf_wr   = 1'b1;
        buf_addr = a[AW-1:0];
        buf_data = d;
        if (accept && a < MAXP) ref_mem[a] = d;
        @(negedge clk);
        buf_wr = 1'b0;
    endtask

    // kind: 0 = packet_wr, 1 = resend, 2 = both strobes together
    task automatic start(input int len, input int kind, input bit ok, input bit push, input string tag);
        @(negedge clk);
        payload_len = len[7:0];
        packet_wr   = (kind != 1);
        resend      = (kind != 0);
        if (ok && push) push_pkt(len);
        @(posedge clk);
        #1;
        check({tag, "_start_tx_wr"}, {31'b0, tx_wr}, {31'b0, ok});
        check({tag, "_start_busy"}, {31'b0, busy}, {31'b0, ok});
        check({tag, "_len_err"}, {31'b0, len_err}, {31'b0, (kind != 1) && !ok});
        if (ok) check({tag, "_start_hdr"}, {24'b0, tx_data}, {24'b0, HDR});
        @(negedge clk);
        packet_wr = 1'b0;
        resend    = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_len_err_pulse"}, {31'b0, len_err}, 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (n < 3000 && !seen) begin
            @(posedge clk);
            n++;
            if (tx_done && exp_q.size() == 0) seen = 1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=%0d_pending required=0", tag, exp_q.size());
            exp_q.delete();
        end else begin
            #1;
            check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        end
    endtask

    task automatic run_pkt(input int len, input int kind, input bit push, input string tag);
        int base;
        base = tx_cnt;
        start(len, kind, 1'b1, push, tag);
        wait_done(tag);
        check({tag, "_pulses"}, tx_cnt - base, len + 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("rst_tx_wr", {31'b0, tx_wr}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_len_err", {31'b0, len_err}, 32'd0);
        check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Resend with no prior packet must do nothing in either build.
        start(0, 1, 1'b0, 1'b0, "resend_none");
        repeat (5) @(negedge clk);

        for (int i = 0; i < MAXP; i++) wr(i, 8'($urandom), 1'b1);
        wr(MAXP, 8'hEE, 1'b1);
        wr(31, 8'h77, 1'b1);

        uart_dly = 3;
        wr(0, 8'h01, 1'b1);
        exp_q.push_back(8'hD5);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h5E);
        run_pkt(1, 0, 1'b0, "len1");
        uart_dly = 0;

        run_pkt(0, 0, 1'b1, "len0");

        start(MAXP + 1, 0, 1'b0, 1'b0, "oversize");
        start(255, 0, 1'b0, 1'b0, "len255");
        repeat (5) @(negedge clk);
        check("oversize_busy", {31'b0, busy}, 32'd0);

        for (int i = 0; i < MAXP; i++) wr(i, 8'h00, 1'b1);
        run_pkt(MAXP, 0, 1'b1, "lenmax");

        for (int i = 0; i < 4; i++) wr(i, 8'($urandom), 1'b1);
        base = tx_cnt;
        start(4, 0, 1'b1, 1'b1, "busy_ign");
        @(negedge clk);
        buf_wr = 1'b1; buf_addr = '0; buf_data = ~ref_mem[0];
        packet_wr = 1'b1; payload_len = 8'd1;
        @(negedge clk);
        buf_wr = 1'b0; packet_wr = 1'b0;
        wait_done("busy_ign");
        check("busy_ign_pulses", tx_cnt - base, 7);

        base = tx_cnt;
        start(4, 0, 1'b1, 1'b1, "mid_rst");
        n = 0;
        while (tx_cnt < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_reached", {31'b0, tx_cnt >= base + 2}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_tx_wr", {31'b0, tx_wr}, 32'd0);
        check("mid_rst_tx_data", {24'b0, tx_data}, 32'd0);
        check("mid_rst_len_err", {31'b0, len_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (8) @(negedge clk);
        run_pkt(4, 0, 1'b1, "post_rst");

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) wr($urandom_range(0, 31), 8'($urandom), 1'b1);
            run_pkt($urandom_range(0, MAXP), 0, 1'b1, "rand");
        end
        start($urandom_range(MAXP + 1, 255), 0, 1'b0, 1'b0, "rand_over");

`ifdef S3G_TX_RESEND_EN
        wr(0, 8'hAA, 1'b1);
        wr(1, 8'h55, 1'b1);
        run_pkt(2, 0, 1'b1, "len2");
        run_pkt(2, 1, 1'b1, "resend");
        wr(0, 8'($urandom), 1'b1);
        run_pkt(2, 1, 1'b1, "resend_new");
        run_pkt(1, 2, 1'b1, "both");
`else
        run_pkt(2, 0, 1'b1, "len2");
        start(2, 1, 1'b0, 1'b0, "resend_off");
`endif

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
